// File: rtl/instr_ctrl_sequencer.sv
// rtl/instr_ctrl_sequencer.sv - hardwired fetch/execute control-step sequencer
// Sequences T0-T2 instruction fetch (with memory wait states), then drives the
// register/ALU strobes for 3-register, MUL/DIV and unary ALU instructions.
// Illegal opcodes or register fields trap into ERR until clear.
module instr_ctrl_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int OPC_WIDTH  = 5,
  parameter int RSEL_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] ir,
  output logic [NUM_REGS-1:0]   reg_in,
  output logic [NUM_REGS-1:0]   reg_out,
  output logic                  PCout,
  output logic                  PCin,
  output logic                  IncPC,
  output logic                  MARin,
  output logic                  MDMuxread,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  Zlowin,
  output logic                  Zhighin,
  output logic                  Zlowout,
  output logic                  Zhighout,
  output logic                  HIin,
  output logic                  LOin,
  output logic [3:0]            alu_op,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int RA_MSB = DATA_WIDTH - 1 - OPC_WIDTH;
  localparam int RB_MSB = RA_MSB - RSEL_WIDTH;
  localparam int RC_MSB = RB_MSB - RSEL_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_TW, S_T2, S_T3, S_T4, S_T5, S_T6, S_ERR
  } state_t;

  typedef enum logic [1:0] {C_THREE, C_MULDIV, C_UNARY, C_ILL} cls_t;

  state_t state_q, state_d;

  // Instruction class and fields captured at T3 so later steps do not depend on ir
  cls_t                  cls_q;
  logic [3:0]            alu_q;
  logic [RSEL_WIDTH-1:0] ra_q, rb_q, rc_q;

  logic [OPC_WIDTH-1:0]  opc;
  logic [RSEL_WIDTH-1:0] ra, rb, rc;
  cls_t                  dec_cls;
  logic [3:0]            dec_alu;
  logic                  dec_ill;
  logic                  unused_ir_bits;

  assign opc = ir[DATA_WIDTH-1 -: OPC_WIDTH];
  assign ra  = ir[RA_MSB -: RSEL_WIDTH];
  assign rb  = ir[RB_MSB -: RSEL_WIDTH];
  assign rc  = ir[RC_MSB -: RSEL_WIDTH];
  assign unused_ir_bits = ^ir[RC_MSB-RSEL_WIDTH:0];

  function automatic logic reg_ok(input logic [RSEL_WIDTH-1:0] r);
    return int'(r) < NUM_REGS;
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [RSEL_WIDTH-1:0] r);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(r) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Opcode decode: class, ALU code, and legality of the fields that class uses
  always_comb begin
    dec_cls = C_ILL;
    dec_alu = 4'd0;
    case (int'(opc))
      3, 4, 5, 6, 7, 8, 9, 10, 11: begin
        dec_cls = C_THREE;
        dec_alu = 4'(int'(opc) - 2);
      end
      15: begin dec_cls = C_MULDIV; dec_alu = 4'd10; end
      16: begin dec_cls = C_MULDIV; dec_alu = 4'd11; end
      17: begin dec_cls = C_UNARY;  dec_alu = 4'd12; end
      18: begin dec_cls = C_UNARY;  dec_alu = 4'd13; end
      default: ;
    endcase
    dec_ill = (dec_cls == C_ILL) || !reg_ok(ra) || !reg_ok(rb) ||
              ((dec_cls == C_THREE) && !reg_ok(rc));
  end

  // State register; clear aborts from any state straight back to IDLE
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Capture decoded instruction at T3 for use in T4-T6
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cls_q <= C_THREE;
      alu_q <= 4'd0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else if (state_q == S_T3) begin
      cls_q <= dec_cls;
      alu_q <= dec_alu;
      ra_q  <= ra;
      rb_q  <= rb;
      rc_q  <= rc;
    end
  end

  // Next-state and per-step strobe decode; final step chains to T0 while run is high
  always_comb begin
    state_d   = state_q;
    reg_in    = '0;
    reg_out   = '0;
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDMuxread = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    alu_op    = 4'd0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        busy = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        busy = 1'b1; Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1; MDRin = 1'b1;
        state_d = mem_ready ? S_T2 : S_TW;
      end
      S_TW: begin
        busy = 1'b1; MDMuxread = 1'b1; MDRin = 1'b1;
        state_d = mem_ready ? S_T2 : S_TW;
      end
      S_T2: begin
        busy = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        busy = 1'b1;
        if (dec_ill) begin
          state_d = S_ERR;
        end else begin
          state_d = S_T4;
          case (dec_cls)
            C_THREE:  begin reg_out = onehot(rb); Yin = 1'b1; end
            C_MULDIV: begin reg_out = onehot(ra); Yin = 1'b1; end
            C_UNARY:  begin reg_out = onehot(rb); alu_op = dec_alu; Zlowin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        busy = 1'b1;
        case (cls_q)
          C_THREE: begin
            reg_out = onehot(rc_q); alu_op = alu_q; Zlowin = 1'b1;
            state_d = S_T5;
          end
          C_MULDIV: begin
            reg_out = onehot(rb_q); alu_op = alu_q; Zhighin = 1'b1; Zlowin = 1'b1;
            state_d = S_T5;
          end
          default: begin
            Zlowout = 1'b1; reg_in = onehot(ra_q); done = 1'b1;
            state_d = run ? S_T0 : S_IDLE;
          end
        endcase
      end
      S_T5: begin
        busy = 1'b1; Zlowout = 1'b1;
        if (cls_q == C_THREE) begin
          reg_in = onehot(ra_q); done = 1'b1;
          state_d = run ? S_T0 : S_IDLE;
        end else begin
          LOin = 1'b1;
          state_d = S_T6;
        end
      end
      S_T6: begin
        busy = 1'b1; Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
        state_d = run ? S_T0 : S_IDLE;
      end
      S_ERR: err = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
